// File: rtl/rrf_wr_ctl_pkg.sv
// rtl/rrf_wr_ctl_pkg.sv - shared backend constants, FSM state enum and helpers for the rrf write controller
//
// Purpose : port count, address-space sizing, controller state encoding and
//           small helper functions shared by rrf_wr_ctl and rrf_wr_squash.
// Ports   : none (package)

package rrf_wr_ctl_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int RRF_PORTS = 9;
    localparam int RRF_AW    = 6;
    localparam int RRF_SQW   = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLR   = 2'd2
    } rrf_state_e;

    // Register file size: 32 base entries plus 16 per extra tile.
    function automatic int rrf_addr_count(input int extra);
        return 32 + 16 * extra;
    endfunction

    // Number of clear cycles needed to cover the register file with all ports.
    function automatic int rrf_clr_cycles(input int extra);
        return (rrf_addr_count(extra) + RRF_PORTS - 1) / RRF_PORTS;
    endfunction

    function automatic logic [RRF_AW-1:0] rrf_clr_addr(input logic [3:0] idx, input int p);
        int a;
        a = RRF_PORTS * int'(32'(idx)) + p;
        return a[RRF_AW-1:0];
    endfunction

    function automatic logic rrf_clr_wen(input logic [3:0] idx, input int p, input int addr_count);
        int a;
        a = RRF_PORTS * int'(32'(idx)) + p;
        return a < addr_count;
    endfunction

    function automatic logic [7:0] rrf_sat_add8(input logic [7:0] a, input logic [RRF_SQW-1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/rrf_wr_squash.sv
// rtl/rrf_wr_squash.sv - combinational same-address squash for one retire bundle
//
// Purpose : masks enables so that at most one write port targets any address;
//           the highest-numbered enabled slot wins. Out-of-range addresses are
//           dropped without being counted as collisions.
// Ports   : en_i     - per-slot enable
//           addr_i   - per-slot register address
//           wen_o    - masked per-slot write enable
//           sq_cnt_o - number of slots squashed by a later same-address slot

module rrf_wr_squash
    import rrf_wr_ctl_pkg::*;
#(
    parameter int ADDR_COUNT = 32
) (
    input  logic [RRF_PORTS-1:0]              en_i,
    input  logic [RRF_PORTS-1:0][RRF_AW-1:0]  addr_i,
    output logic [RRF_PORTS-1:0]              wen_o,
    output logic [RRF_SQW-1:0]                sq_cnt_o
);

    logic [RRF_PORTS-1:0] valid;
    logic [RRF_PORTS-1:0] squash;

    always_comb begin
        valid    = '0;
        squash   = '0;
        sq_cnt_o = '0;
        for (int i = 0; i < RRF_PORTS; i++) begin
            valid[i] = en_i[i] && (32'(addr_i[i]) < 32'(ADDR_COUNT));
        end
        // Two out-of-range slots with equal addresses are both invalid, so
        // neither is counted.
        for (int i = 0; i < RRF_PORTS; i++) begin
            for (int j = i + 1; j < RRF_PORTS; j++) begin
                if (valid[i] && valid[j] && (addr_i[i] == addr_i[j])) begin
                    squash[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < RRF_PORTS; i++) begin
            sq_cnt_o = sq_cnt_o + RRF_SQW'(squash[i]);
        end
        wen_o = valid & ~squash;
    end

endmodule

// File: rtl/rrf_wr_ctl.sv
// rtl/rrf_wr_ctl.sv - retire-bundle write controller with whole-file clear for the rrf
//
// Purpose : buffers retire bundles in a 2-entry FIFO, pops one per cycle into
//           registered write-port outputs (with same-address squash), and on
//           request drains and then zeroes the whole register file.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           in_vld/in_rdy   - retire bundle handshake
//           in_en/addr/data - per-slot enable, address and data
//           clear_req       - single-cycle request to zero the register file
//           wr_addr/data/wen- rrf write ports 0..8 (registered)
//           busy            - high while draining or clearing
//           coll_cnt        - saturating count of squashed slots

module rrf_wr_ctl
    import rrf_wr_ctl_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_WIDTH,
    parameter int EXTRA      = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    input  logic [RRF_PORTS-1:0]                  in_en,
    input  logic [RRF_PORTS-1:0][RRF_AW-1:0]      in_addr,
    input  logic [RRF_PORTS-1:0][DATA_WIDTH-1:0]  in_data,
    input  logic                                  clear_req,
    output logic [RRF_PORTS-1:0][RRF_AW-1:0]      wr_addr,
    output logic [RRF_PORTS-1:0][DATA_WIDTH-1:0]  wr_data,
    output logic [RRF_PORTS-1:0]                  wr_wen,
    output logic                                  busy,
    output logic [7:0]                            coll_cnt
);

    localparam int         ADDR_COUNT = rrf_addr_count(EXTRA);
    localparam logic [3:0] CLR_LAST   = 4'(rrf_clr_cycles(EXTRA));

    rrf_state_e                           state_q, state_d;
    logic [1:0]                           cnt_q, cnt_d;
    logic [3:0]                           idx_q, idx_d;
    logic [RRF_PORTS-1:0]                 hd_en_q, hd_en_d, tl_en_q, tl_en_d;
    logic [RRF_PORTS-1:0][RRF_AW-1:0]     hd_addr_q, hd_addr_d, tl_addr_q, tl_addr_d;
    logic [RRF_PORTS-1:0][DATA_WIDTH-1:0] hd_data_q, hd_data_d, tl_data_q, tl_data_d;
    logic [RRF_PORTS-1:0]                 wen_q, wen_d;
    logic [RRF_PORTS-1:0][RRF_AW-1:0]     waddr_q, waddr_d;
    logic [RRF_PORTS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]                           coll_q, coll_d;

    logic                 push;
    logic                 pop;
    logic [RRF_PORTS-1:0] sq_wen;
    logic [RRF_SQW-1:0]   sq_cnt;

    rrf_wr_squash #(
        .ADDR_COUNT (ADDR_COUNT)
    ) u_squash (
        .en_i     (hd_en_q),
        .addr_i   (hd_addr_q),
        .wen_o    (sq_wen),
        .sq_cnt_o (sq_cnt)
    );

    // rst gates in_rdy so no bundle appears accepted during the reset cycle.
    assign in_rdy   = !rst && (state_q == RUN) && (cnt_q != 2'd2);
    assign busy     = (state_q != RUN);
    assign wr_wen   = wen_q;
    assign wr_addr  = waddr_q;
    assign wr_data  = wdata_q;
    assign coll_cnt = coll_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        hd_en_d   = hd_en_q;
        hd_addr_d = hd_addr_q;
        hd_data_d = hd_data_q;
        tl_en_d   = tl_en_q;
        tl_addr_d = tl_addr_q;
        tl_data_d = tl_data_q;
        wen_d     = '0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        coll_d    = coll_q;

        // DRAIN keeps popping so bundles accepted before the clear land first.
        pop  = (state_q != CLR) && (cnt_q != 2'd0);
        push = in_vld && in_rdy;

        if (pop) begin
            wen_d   = sq_wen;
            waddr_d = hd_addr_q;
            wdata_d = hd_data_q;
            coll_d  = rrf_sat_add8(coll_q, sq_cnt);
        end

        if (push && pop) begin
            // Only reachable at count 1: the head leaves and the new bundle
            // takes its place, so count and order are preserved.
            hd_en_d   = in_en;
            hd_addr_d = in_addr;
            hd_data_d = in_data;
        end else if (pop) begin
            hd_en_d   = tl_en_q;
            hd_addr_d = tl_addr_q;
            hd_data_d = tl_data_q;
            cnt_d     = cnt_q - 2'd1;
        end else if (push) begin
            if (cnt_q == 2'd0) begin
                hd_en_d   = in_en;
                hd_addr_d = in_addr;
                hd_data_d = in_data;
            end else begin
                tl_en_d   = in_en;
                tl_addr_d = in_addr;
                tl_data_d = in_data;
            end
            cnt_d = cnt_q + 2'd1;
        end

        unique case (state_q)
            RUN: begin
                if (clear_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt_q == 2'd0) && (wen_q == '0)) begin
                    state_d = CLR;
                    idx_d   = '0;
                end
            end
            CLR: begin
                if (idx_q == CLR_LAST) begin
                    state_d = RUN;
                    idx_d   = '0;
                end else begin
                    for (int p = 0; p < RRF_PORTS; p++) begin
                        waddr_d[p] = rrf_clr_addr(idx_q, p);
                        wdata_d[p] = '0;
                        wen_d[p]   = rrf_clr_wen(idx_q, p, ADDR_COUNT);
                    end
                    idx_d = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            idx_q     <= '0;
            hd_en_q   <= '0;
            hd_addr_q <= '0;
            hd_data_q <= '0;
            tl_en_q   <= '0;
            tl_addr_q <= '0;
            tl_data_q <= '0;
            wen_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            coll_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hd_en_q   <= hd_en_d;
            hd_addr_q <= hd_addr_d;
            hd_data_q <= hd_data_d;
            tl_en_q   <= tl_en_d;
            tl_addr_q <= tl_addr_d;
            tl_data_q <= tl_data_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            coll_q    <= coll_d;
        end
    end

endmodule

// File: tb/tb_rrf_wr_ctl.sv
// tb/tb_rrf_wr_ctl.sv - scoreboard bench for rrf_wr_ctl

module tb_rrf_wr_ctl;

    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_vld;
    logic                 in_rdy;
    logic [8:0]           in_en;
    logic [8:0][5:0]      in_addr;
    logic [8:0][DW-1:0]   in_data;
    logic                 clear_req;
    logic [8:0][5:0]      wr_addr;
    logic [8:0][DW-1:0]   wr_data;
    logic [8:0]           wr_wen;
    logic                 busy;
    logic [7:0]           coll_cnt;

    always #5 clk = ~clk;

    rrf_wr_ctl #(
        .DATA_WIDTH (DW),
        .EXTRA      (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .in_en     (in_en),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .clear_req (clear_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_wen    (wr_wen),
        .busy      (busy),
        .coll_cnt  (coll_cnt)
    );

    typedef struct {
        logic [8:0]         wen;
        logic [8:0][5:0]    addr;
        logic [8:0][DW-1:0] data;
        bit                 is_clr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Hand-computed enable masks for the four clear cycles of a 32-entry file.
    logic [8:0] clr_wen_tbl [4] = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h01F};

    logic [8:0][5:0]    a;
    logic [8:0][DW-1:0] d;
    int                 n;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic [8:0] wen, input logic [8:0][5:0] ea,
                            input logic [8:0][DW-1:0] ed, input bit c);
        exp_t e;
        e.wen    = wen;
        e.addr   = ea;
        e.data   = ed;
        e.is_clr = c;
        exp_q.push_back(e);
    endtask

    task automatic push_clr(input int ncyc);
        logic [8:0][5:0] ca;
        for (int k = 0; k < ncyc; k++) begin
            for (int p = 0; p < 9; p++) ca[p] = 6'(9 * k + p);
            push_exp(clr_wen_tbl[k], ca, '0, 1'b1);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [8:0] en, input logic [8:0][5:0] sa,
                        input logic [8:0][DW-1:0] sd, input logic [8:0] exp_wen, input bit clr);
        int w = 0;
        in_vld    = 1'b1;
        in_en     = en;
        in_addr   = sa;
        in_data   = sd;
        clear_req = clr;
        while (!in_rdy && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("send_rdy", 64'(in_rdy), 64'd1);
        if (exp_wen != '0) push_exp(exp_wen, sa, sd, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_vld    = 1'b0;
        clear_req = 1'b0;
    endtask

    // Monitor: every cycle with a write pops and compares the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!$isunknown(wr_wen) && wr_wen != '0) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_wen", 64'(wr_wen), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_wen", 64'(wr_wen), 64'(e.wen));
                    for (int p = 0; p < 9; p++) begin
                        if (e.wen[p]) begin
                            chk("mon_addr", 64'(wr_addr[p]), 64'(e.addr[p]));
                            chk("mon_data", 64'(wr_data[p]), 64'(e.data[p]));
                        end
                    end
                    if (e.is_clr) chk("mon_clr_busy", 64'(busy), 64'd1);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_vld    = 1'b0;
        in_en     = '0;
        in_addr   = '0;
        in_data   = '0;
        clear_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wen", 64'(wr_wen), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_coll", 64'(coll_cnt), 64'd0);
        chk("rst_rdy", 64'(in_rdy), 64'd0);
        chk("rst_addr", 64'(wr_addr), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 64'(in_rdy), 64'd1);

        // Single bundle: latency and idle-cycle wen.
        a = '0; d = '0;
        a[0] = 6'd5; d[0] = 16'h000A;
        send(9'h001, a, d, 9'h001, 1'b0);
        chk("t1_wen_accept_cycle", 64'(wr_wen), 64'd0);
        @(negedge clk);
        chk("t1_wen", 64'(wr_wen), 64'h001);
        chk("t1_addr0", 64'(wr_addr[0]), 64'd5);
        chk("t1_data0", 64'(wr_data[0]), 64'h000A);
        @(negedge clk);
        chk("t1_wen_idle", 64'(wr_wen), 64'd0);

        // Slots 2, 4, 7 share address 9; slot 0 writes address 1.
        a = '0;
        for (int p = 0; p < 9; p++) d[p] = 16'(16'h0100 + p);
        a[0] = 6'd1; a[2] = 6'd9; a[4] = 6'd9; a[7] = 6'd9;
        send(9'h095, a, d, 9'h081, 1'b0);
        @(negedge clk);
        chk("t2_wen", 64'(wr_wen), 64'h081);
        chk("t2_coll", 64'(coll_cnt), 64'd2);

        // Out-of-range address 40 dropped without counting a collision.
        a = '0;
        a[0] = 6'd40; a[1] = 6'd3; a[2] = 6'd40;
        send(9'h007, a, d, 9'h002, 1'b0);
        @(negedge clk);
        chk("t3_wen", 64'(wr_wen), 64'h002);
        chk("t3_coll", 64'(coll_cnt), 64'd2);

        // Three back-to-back bundles.
        for (int i = 0; i < 3; i++) begin
            a = '0; d = '0;
            a[0] = 6'(10 + i); d[0] = 16'(16'h0011 * (i + 1));
            a[8] = 6'(30 - i); d[8] = 16'(16'h0F00 + i);
            send(9'h101, a, d, 9'h101, 1'b0);
        end
        chk("t4_second_addr", 64'(wr_addr[0]), 64'd11);
        @(negedge clk);
        chk("t4_third_addr", 64'(wr_addr[0]), 64'd12);
        chk("t4_third_data", 64'(wr_data[8]), 64'h0F02);
        @(negedge clk);
        chk("t4_idle", 64'(wr_wen), 64'd0);

        // 32 bundles of nine same-address slots: 2 + 32*8 saturates at 255.
        for (int i = 0; i < 32; i++) begin
            for (int p = 0; p < 9; p++) begin
                a[p] = 6'd20;
                d[p] = 16'(i * 16 + p);
            end
            send(9'h1FF, a, d, 9'h100, 1'b0);
        end
        @(negedge clk);
        chk("t5_coll_sat", 64'(coll_cnt), 64'd255);

        // Two bundles, clear requested together with the second.
        a = '0; d = '0;
        a[0] = 6'd1; d[0] = 16'h00AA;
        send(9'h001, a, d, 9'h001, 1'b0);
        a = '0; d = '0;
        a[1] = 6'd2; d[1] = 16'h00BB;
        send(9'h002, a, d, 9'h002, 1'b1);
        push_clr(4);
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_rdy_busy", 64'(in_rdy), 64'd0);
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t6_busy_done", 64'(busy), 64'd0);
        chk("t6_rdy_after", 64'(in_rdy), 64'd1);
        repeat (3) @(negedge clk);
        chk("t6_no_reclear", 64'(wr_wen), 64'd0);

        // Reset during clear cycle 2.
        clear_req = 1'b1;
        push_clr(3);
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        while (!(wr_wen != '0 && wr_addr[0] == 6'd18) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t7_reach_clr2", 64'(wr_addr[0]), 64'd18);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_wen", 64'(wr_wen), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_coll", 64'(coll_cnt), 64'd0);
        chk("t7_addr", 64'(wr_addr), 64'd0);
        chk("t7_rdy_in_rst", 64'(in_rdy), 64'd0);
        rst = 1'b0;
        #1;
        chk("t7_rdy_after", 64'(in_rdy), 64'd1);

        repeat (3) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
